// File: rtl/burst_weight_loader.sv
// burst_weight_loader
//   Copies a block of words from DDR (AXI4 read channel) into a BRAM.
//   One burst is in flight at a time. Bursts never exceed MAX_BURST beats
//   and never cross a 4 KB boundary.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   start                pulse: begin a load (ignored while busy)
//   base_addr            DDR byte address of the first word (word-aligned)
//   num_words            words to load (clamped to MEM_DEPTH)
//   busy / done / error  status: busy while loading, one-cycle done pulse,
//                        sticky error flag
//   ar* / r*             AXI4 read address and read data channels
//   bram_*               BRAM write port (one write per accepted beat)
//
// Optional feature (macro BURST_WEIGHT_LOADER_RESP_CHECK_EN)
//   Defined:   a non-OKAY rresp sets error and drops that beat's write;
//              an rlast that disagrees with the beat count sets error.
//              After an error the burst drains and the load ends.
//   Undefined: error is tied 0; rresp and rlast are ignored.
module burst_weight_loader #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MEM_DEPTH       = 1024,
  parameter int unsigned BRAM_ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int unsigned MAX_BURST       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  input  logic [BRAM_ADDR_WIDTH:0]   num_words,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [ADDR_WIDTH-1:0]      araddr,
  output logic [7:0]                 arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [DATA_WIDTH-1:0]      rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rlast,
  input  logic                       rvalid,
  output logic                       rready,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0]      bram_din,
  output logic                       bram_we,
  output logic                       bram_en
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned SIZE  = $clog2(BYTES);
  localparam int unsigned CW    = BRAM_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [ADDR_WIDTH-1:0]      r_base;
  logic [CW-1:0]              r_total;
  logic [CW-1:0]              r_index;
  logic [8:0]                 r_len;
  logic [8:0]                 r_beat;
  logic                       r_we;
  logic [BRAM_ADDR_WIDTH-1:0] r_baddr;
  logic [DATA_WIDTH-1:0]      r_din;

  logic [CW-1:0]         w_clamped;
  logic [CW-1:0]         w_remaining;
  logic [ADDR_WIDTH-1:0] w_cur_addr;
  logic [12:0]           w_bytes_4k;
  logic [12:0]           w_words_4k;
  logic [8:0]            w_len;
  logic                  w_beat;
  logic                  w_last_beat;
  logic                  w_stop;
  logic                  w_drop;

  assign w_clamped   = (32'(num_words) > MEM_DEPTH) ? CW'(MEM_DEPTH) : num_words;
  assign w_remaining = r_total - r_index;
  assign w_cur_addr  = r_base + (ADDR_WIDTH'(r_index) << SIZE);

  // Words left in the current 4 KB page, counted from the next burst address.
  assign w_bytes_4k = 13'h1000 - {1'b0, w_cur_addr[11:0]};
  assign w_words_4k = w_bytes_4k >> SIZE;

  // Burst length = min(MAX_BURST, remaining words, words left in page).
  // Only consumed in ADDR, where r_index is frozen, so it is stable there.
  always_comb begin
    w_len = 9'(MAX_BURST);
    if (32'(w_words_4k) < 32'(w_len)) w_len = 9'(w_words_4k);
    if (32'(w_remaining) < 32'(w_len)) w_len = 9'(w_remaining);
  end

  assign w_beat      = (r_state == DATA) && rvalid;
  assign w_last_beat = (r_beat == r_len - 9'd1);

`ifdef BURST_WEIGHT_LOADER_RESP_CHECK_EN
  logic r_error;
  logic w_resp_bad;
  logic w_err_now;

  assign w_resp_bad = w_beat && (rresp != 2'b00);
  assign w_err_now  = w_resp_bad || (w_beat && (rlast != w_last_beat));
  assign w_drop     = w_resp_bad;
  assign w_stop     = r_error || w_err_now;
  assign error      = r_error;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_error <= 1'b0;
    end else if ((r_state == IDLE) && start) begin
      r_error <= 1'b0;
    end else if (w_err_now) begin
      r_error <= 1'b1;
    end
  end
`else
  logic w_unused;

  assign w_unused = ^{rresp, rlast};
  assign w_drop   = 1'b0;
  assign w_stop   = 1'b0;
  assign error    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = (w_clamped == '0) ? DONE : ADDR;
      end
      ADDR: begin
        if (arready) w_state_next = DATA;
      end
      DATA: begin
        // Burst end comes from the internal count, not from rlast.
        if (w_beat && w_last_beat) begin
          w_state_next = ((w_remaining == CW'(1)) || w_stop) ? DONE : ADDR;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base  <= '0;
      r_total <= '0;
      r_index <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_we    <= 1'b0;
      r_baddr <= '0;
      r_din   <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_base  <= base_addr;
            r_total <= w_clamped;
            r_index <= '0;
          end
        end
        ADDR: begin
          if (arready) begin
            r_len  <= w_len;
            r_beat <= '0;
          end
        end
        DATA: begin
          if (w_beat) begin
            r_beat  <= r_beat + 9'd1;
            r_index <= r_index + CW'(1);
            r_baddr <= r_index[BRAM_ADDR_WIDTH-1:0];
            r_din   <= rdata;
            r_we    <= !w_drop;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign arvalid   = (r_state == ADDR);
  assign araddr    = arvalid ? w_cur_addr : '0;
  assign arlen     = arvalid ? 8'(w_len - 9'd1) : '0;
  assign arsize    = 3'(SIZE);
  assign arburst   = 2'b01;
  assign rready    = (r_state == DATA);
  assign bram_addr = r_baddr;
  assign bram_din  = r_din;
  assign bram_we   = r_we;
  assign bram_en   = r_we;

endmodule

// File: tb/tb_burst_weight_loader.sv
module tb_burst_weight_loader;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned MD  = 1024;
  localparam int unsigned BAW = 10;
  localparam int unsigned MB  = 16;
`ifdef BURST_WEIGHT_LOADER_RESP_CHECK_EN
  localparam bit RESP_CHK = 1'b1;
`else
  localparam bit RESP_CHK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [AW-1:0]  base_addr;
  logic [BAW:0]   num_words;
  logic           busy, done, error;
  logic [AW-1:0]  araddr;
  logic [7:0]     arlen;
  logic [2:0]     arsize;
  logic [1:0]     arburst;
  logic           arvalid, arready;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rlast, rvalid, rready;
  logic [BAW-1:0] bram_addr;
  logic [DW-1:0]  bram_din;
  logic           bram_we, bram_en;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0]    exp_ar_addr_q[$];
  logic [7:0]     exp_ar_len_q[$];
  logic [BAW-1:0] exp_wr_addr_q[$];
  logic [31:0]    exp_wr_data_q[$];

  always #5 clk = ~clk;

  burst_weight_loader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(MD), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .error(error),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
    .bram_en(bram_en)
  );

  // Contents of the DDR model: a distinct word per byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({busy, done, error, arvalid, rready, bram_we, bram_en} !== 7'b0)
      $display("FAIL reset_ctrl: got %b, expected 0000000",
               {busy, done, error, arvalid, rready, bram_we, bram_en});
    else pass_cnt++;
    total_cnt++;
    if (araddr !== '0 || arlen !== '0 || bram_addr !== '0 || bram_din !== '0)
      $display("FAIL reset_data: got araddr=%h arlen=%0d baddr=%0d bdin=%h, expected all 0",
               araddr, arlen, bram_addr, bram_din);
    else pass_cnt++;
    total_cnt++;
    if (arsize !== 3'd2 || arburst !== 2'b01)
      $display("FAIL reset_const: got arsize=%0d arburst=%b, expected 2 01", arsize, arburst);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Drives one load and acts as the AXI slave; expected bursts and writes are
  // queued up front from a reference model and popped as the DUT produces them.
  task automatic run_load(input logic [31:0] base, input int unsigned nreq,
                          input int unsigned ar_delay, input bit toggle,
                          input int err_beat, input bit restart, input string name);
    int unsigned n, idx, len, w4k, hold, beats_left, cycles, dones;
    int gbeat;
    logic [31:0] a, cur_addr, held_addr, ea, ed;
    logic [7:0] held_len, el;
    logic [BAW-1:0] ewa;
    bit burst_active, ar_seen, finished, tog, done_prev, exp_err;

    n = (nreq > MD) ? MD : nreq;
    exp_ar_addr_q.delete(); exp_ar_len_q.delete();
    exp_wr_addr_q.delete(); exp_wr_data_q.delete();
    idx = 0;
    while (idx < n) begin
      a   = base + 32'(idx * 4);
      w4k = (4096 - (a % 4096)) / 4;
      len = MB;
      if (n - idx < len) len = n - idx;
      if (w4k < len) len = w4k;
      exp_ar_addr_q.push_back(a);
      exp_ar_len_q.push_back(8'(len - 1));
      idx += len;
    end
    for (int i = 0; i < int'(n); i++) begin
      if (!(RESP_CHK && i == err_beat)) begin
        exp_wr_addr_q.push_back(BAW'(i));
        exp_wr_data_q.push_back(mem_word(base + 32'(i * 4)));
      end
    end
    exp_err = RESP_CHK && (err_beat >= 0) && (err_beat < int'(n));

    @(negedge clk);
    start = 1'b1; base_addr = base; num_words = (BAW+1)'(nreq);
    @(negedge clk);
    cycles = 0; dones = 0; gbeat = 0; hold = 0; beats_left = 0;
    burst_active = 0; ar_seen = 0; finished = 0; tog = 0; done_prev = 0;
    held_addr = '0; held_len = '0; cur_addr = '0;
    while (!finished && cycles < 5000) begin
      start = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      if (restart && cycles == 3) begin
        start = 1'b1; base_addr = 32'hDEAD_0000; num_words = 11'd5;
      end
      if (cycles == 0) begin
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %b, expected 1", name, busy);
        else pass_cnt++;
      end
      if (bram_we) begin
        total_cnt++;
        if (exp_wr_addr_q.size() == 0)
          $display("FAIL %s extra_write: got addr=%0d data=%h, expected no write",
                   name, bram_addr, bram_din);
        else begin
          ewa = exp_wr_addr_q.pop_front();
          ed  = exp_wr_data_q.pop_front();
          if (bram_addr !== ewa || bram_din !== ed || bram_en !== 1'b1)
            $display("FAIL %s bram_write: got addr=%0d data=%h en=%b, expected addr=%0d data=%h en=1",
                     name, bram_addr, bram_din, bram_en, ewa, ed);
          else pass_cnt++;
        end
      end
      if (arvalid) begin
        if (burst_active) begin
          total_cnt++;
          $display("FAIL %s outstanding: got arvalid=1 during data phase, expected 0", name);
        end else if (!ar_seen) begin
          ar_seen = 1; held_addr = araddr; held_len = arlen; hold = 0;
          total_cnt++;
          if (exp_ar_addr_q.size() == 0)
            $display("FAIL %s extra_burst: got araddr=%h arlen=%0d, expected none", name, araddr, arlen);
          else begin
            ea = exp_ar_addr_q.pop_front();
            el = exp_ar_len_q.pop_front();
            if (araddr !== ea || arlen !== el)
              $display("FAIL %s burst: got araddr=%h arlen=%0d, expected araddr=%h arlen=%0d",
                       name, araddr, arlen, ea, el);
            else pass_cnt++;
          end
        end else begin
          total_cnt++;
          if (araddr !== held_addr || arlen !== held_len)
            $display("FAIL %s ar_stable: got araddr=%h arlen=%0d, expected araddr=%h arlen=%0d",
                     name, araddr, arlen, held_addr, held_len);
          else pass_cnt++;
        end
        if (!burst_active) begin
          if (hold >= ar_delay) begin
            arready = 1'b1; burst_active = 1; ar_seen = 0;
            beats_left = held_len + 1; cur_addr = held_addr;
          end else hold++;
        end
      end else if (burst_active && rready && beats_left > 0) begin
        tog = toggle ? !tog : 1'b1;
        if (tog) begin
          rvalid = 1'b1;
          rdata  = mem_word(cur_addr);
          rlast  = (beats_left == 1);
          rresp  = (gbeat == err_beat) ? 2'b10 : 2'b00;
          beats_left--; cur_addr += 4; gbeat++;
          if (beats_left == 0) burst_active = 0;
        end
      end
      if (done_prev) begin
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0)
          $display("FAIL %s done_pulse: got done=%b busy=%b, expected 0 0", name, done, busy);
        else pass_cnt++;
        finished = 1;
      end else if (done) begin
        dones++; done_prev = 1;
      end
      cycles++;
      if (!finished) @(negedge clk);
    end
    start = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    total_cnt++;
    if (!finished) $display("FAIL %s timeout: got no done within %0d cycles, expected done", name, cycles);
    else pass_cnt++;
    total_cnt++;
    if (dones != 1) $display("FAIL %s done_count: got %0d, expected 1", name, dones);
    else pass_cnt++;
    total_cnt++;
    if (exp_wr_addr_q.size() != 0 || exp_ar_addr_q.size() != 0)
      $display("FAIL %s leftovers: got %0d writes %0d bursts missing, expected 0 0",
               name, exp_wr_addr_q.size(), exp_ar_addr_q.size());
    else pass_cnt++;
    total_cnt++;
    if (error !== exp_err) $display("FAIL %s error_flag: got %b, expected %b", name, error, exp_err);
    else pass_cnt++;
  endtask

  task automatic test_multi_burst();
    run_load(32'h0000_1000, 40, 0, 1'b0, -1, 1'b0, "multi_burst");
  endtask

  task automatic test_4k_boundary();
    run_load(32'h0000_0FF8, 8, 0, 1'b0, -1, 1'b0, "boundary_4k");
  endtask

  task automatic test_zero_words();
    @(negedge clk);
    start = 1'b1; base_addr = 32'h0000_5000; num_words = '0;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (done !== 1'b1 || arvalid !== 1'b0 || bram_we !== 1'b0)
      $display("FAIL zero_done: got done=%b arvalid=%b we=%b, expected 1 0 0", done, arvalid, bram_we);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || arvalid !== 1'b0 || bram_we !== 1'b0 || busy !== 1'b0)
      $display("FAIL zero_after: got done=%b arvalid=%b we=%b busy=%b, expected 0 0 0 0",
               done, arvalid, bram_we, busy);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    run_load(32'h0000_2000, 20, 5, 1'b1, -1, 1'b1, "backpressure");
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    start = 1'b1; base_addr = 32'h0000_3000; num_words = 11'd16;
    @(negedge clk);
    start = 1'b0; arready = 1'b1;
    total_cnt++;
    if (arvalid !== 1'b1) $display("FAIL rstmid_ar: got arvalid=%b, expected 1", arvalid);
    else pass_cnt++;
    @(negedge clk);
    arready = 1'b0; rvalid = 1'b1; rdata = mem_word(32'h3000);
    @(negedge clk);
    rdata = mem_word(32'h3004);
    @(negedge clk);
    rdata = mem_word(32'h3008); rst = 1'b1;
    #1;
    total_cnt++;
    if ({busy, done, error, arvalid, rready, bram_we, bram_en} !== 7'b0)
      $display("FAIL rstmid_ctrl: got %b, expected 0000000",
               {busy, done, error, arvalid, rready, bram_we, bram_en});
    else pass_cnt++;
    total_cnt++;
    if (araddr !== '0 || arlen !== '0 || bram_addr !== '0 || bram_din !== '0)
      $display("FAIL rstmid_data: got araddr=%h arlen=%0d baddr=%0d bdin=%h, expected all 0",
               araddr, arlen, bram_addr, bram_din);
    else pass_cnt++;
    @(negedge clk);
    rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total_cnt++;
      if (arvalid !== 1'b0 || bram_we !== 1'b0 || busy !== 1'b0)
        $display("FAIL rstmid_quiet: got arvalid=%b we=%b busy=%b, expected 0 0 0",
                 arvalid, bram_we, busy);
      else pass_cnt++;
    end
    run_load(32'h0000_3000, 16, 0, 1'b0, -1, 1'b0, "after_reset");
  endtask

  task automatic test_resp_error();
    run_load(32'h0000_4000, 16, 0, 1'b0, 2, 1'b0, "resp_error");
  endtask

  task automatic test_clamp();
    run_load(32'h0000_8000, 1500, 0, 1'b0, -1, 1'b0, "clamp");
  endtask

  initial begin
    test_reset();
    test_multi_burst();
    test_4k_boundary();
    test_zero_words();
    test_backpressure();
    test_reset_mid_burst();
    test_resp_error();
    test_clamp();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
